// File: rtl/mc_defs.sv
// rtl/mc_defs.sv - shared state, opcode and control-select encodings for the controller and datapath muxes
package mc_defs;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    IC_NOP, IC_ADDU, IC_SUBU, IC_JR, IC_ORI, IC_LUI,
    IC_LW, IC_SW, IC_BEQ, IC_J, IC_JAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  // Widths of the ALU and jump-mode fields are parameters of the controller, so these stay untyped ints.
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_OR  = 2;
  localparam int ALU_LUI = 3;

  localparam int JM_PC4    = 0;
  localparam int JM_BRANCH = 1;
  localparam int JM_JUMP   = 2;
  localparam int JM_JR     = 3;

  localparam logic [2:0] EXT_ZERO    = 3'd0;
  localparam logic [2:0] EXT_SIGN    = 3'd1;
  localparam logic [2:0] EXT_UPPER16 = 3'd2;

  localparam logic [1:0] WA_RT = 2'd0;
  localparam logic [1:0] WA_RD = 2'd1;
  localparam logic [1:0] WA_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  function automatic logic is_mem_op(input iclass_t c);
    return (c == IC_LW) || (c == IC_SW);
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - memory request/ready handshake between the controller and memory
interface mc_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational instruction word to instruction class plus legality flag
import mc_defs::*;

module mc_decode (
  input  logic [31:0] instr,
  output iclass_t     iclass,
  output logic        legal
);

  always_comb begin
    iclass = IC_NOP;
    legal  = 1'b1;
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADDU: iclass = IC_ADDU;
          FN_SUBU: iclass = IC_SUBU;
          FN_JR:   iclass = IC_JR;
          FN_SLL: begin
            iclass = IC_NOP;
            legal  = (instr[25:6] == 20'h0);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_J:    iclass = IC_J;
      OP_JAL:  iclass = IC_JAL;
      OP_BEQ:  iclass = IC_BEQ;
      OP_ORI:  iclass = IC_ORI;
      OP_LUI:  iclass = IC_LUI;
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout
// Optional MC_CONTROL_PERF_EN adds perf_cycles/perf_retired counters.
import mc_defs::*;

module mc_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_OP_W    = 5,
  parameter int JMODE_W     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr,
  input  logic                alu_zero,
  mc_control_if.master        mem,
  output logic                cw_ir_enable,
  output logic                cw_pc_enable,
  output logic [JMODE_W-1:0]  cw_npc_jump_mode,
  output logic                cw_rf_write_enable,
  output logic [1:0]          cm_rf_write_addr,
  output logic [1:0]          cm_rf_write_data,
  output logic                cm_alu_num2,
  output logic [ALU_OP_W-1:0] cw_alu_op,
  output logic [2:0]          cw_ext_mode,
  output logic [2:0]          state,
  output logic                halted
`ifdef MC_CONTROL_PERF_EN
  ,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_retired
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t     state_q, state_next;
  logic       run_q;
  logic [CNT_W-1:0] wait_cnt;
  iclass_t    iclass;
  logic       legal;
  logic       stall;
  logic       timeout_hit;

  mc_decode u_decode (
    .instr  (instr),
    .iclass (iclass),
    .legal  (legal)
  );

  assign state       = state_q;
  assign stall       = mem.mem_req && !mem.mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && stall && (32'(wait_cnt) == 32'(MEM_TIMEOUT - 1));

  // run_q keeps FETCH from requesting in the first cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      run_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_next;
      run_q    <= 1'b1;
      wait_cnt <= (MEM_TIMEOUT != 0 && stall && state_next == state_q) ? wait_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_FETCH: begin
        if (run_q) begin
          if (mem.mem_ready)    state_next = ST_DECODE;
          else if (timeout_hit) state_next = ST_ERROR;
        end
      end
      ST_DECODE: begin
        if (!legal)                state_next = ST_ERROR;
        else if (iclass == IC_J)   state_next = ST_FETCH;
        else if (iclass == IC_JAL) state_next = ST_WB;
        else                       state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_mem_op(iclass))                        state_next = ST_MEM;
        else if (iclass == IC_BEQ || iclass == IC_JR) state_next = ST_FETCH;
        else                                          state_next = ST_WB;
      end
      ST_MEM: begin
        if (mem.mem_ready)    state_next = (iclass == IC_SW) ? ST_FETCH : ST_WB;
        else if (timeout_hit) state_next = ST_ERROR;
      end
      ST_WB:    state_next = ST_FETCH;
      default:  state_next = ST_ERROR;
    endcase
  end

  always_comb begin
    mem.mem_req        = 1'b0;
    mem.mem_we         = 1'b0;
    cw_ir_enable       = 1'b0;
    cw_pc_enable       = 1'b0;
    cw_npc_jump_mode   = JMODE_W'(JM_PC4);
    cw_rf_write_enable = 1'b0;
    cm_rf_write_addr   = WA_RT;
    cm_rf_write_data   = WD_ALU;
    cm_alu_num2        = 1'b0;
    cw_alu_op          = ALU_OP_W'(ALU_ADD);
    cw_ext_mode        = EXT_ZERO;
    halted             = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (run_q) begin
          mem.mem_req  = 1'b1;
          cw_ir_enable = mem.mem_ready;
        end
      end
      ST_DECODE: begin
        if (legal && iclass == IC_J) begin
          cw_pc_enable     = 1'b1;
          cw_npc_jump_mode = JMODE_W'(JM_JUMP);
        end
      end
      ST_EXEC: begin
        case (iclass)
          IC_SUBU: cw_alu_op = ALU_OP_W'(ALU_SUB);
          IC_ORI: begin
            cw_alu_op   = ALU_OP_W'(ALU_OR);
            cw_ext_mode = EXT_ZERO;
            cm_alu_num2 = 1'b1;
          end
          IC_LUI: begin
            cw_alu_op   = ALU_OP_W'(ALU_LUI);
            cw_ext_mode = EXT_UPPER16;
            cm_alu_num2 = 1'b1;
          end
          IC_LW, IC_SW: begin
            cw_alu_op   = ALU_OP_W'(ALU_ADD);
            cw_ext_mode = EXT_SIGN;
            cm_alu_num2 = 1'b1;
          end
          IC_BEQ: begin
            cw_alu_op        = ALU_OP_W'(ALU_SUB);
            cw_pc_enable     = 1'b1;
            cw_npc_jump_mode = alu_zero ? JMODE_W'(JM_BRANCH) : JMODE_W'(JM_PC4);
          end
          IC_JR: begin
            cw_pc_enable     = 1'b1;
            cw_npc_jump_mode = JMODE_W'(JM_JR);
          end
          default: cw_alu_op = ALU_OP_W'(ALU_ADD);
        endcase
      end
      ST_MEM: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = (iclass == IC_SW);
        cw_pc_enable = (iclass == IC_SW) && mem.mem_ready;
      end
      ST_WB: begin
        cw_pc_enable       = 1'b1;
        cw_rf_write_enable = (iclass != IC_NOP);
        case (iclass)
          IC_ORI, IC_LUI: begin
            cm_rf_write_addr = WA_RT;
            cm_rf_write_data = WD_ALU;
          end
          IC_LW: begin
            cm_rf_write_addr = WA_RT;
            cm_rf_write_data = WD_MDR;
          end
          IC_JAL: begin
            cm_rf_write_addr = WA_RA;
            cm_rf_write_data = WD_PC4;
            cw_npc_jump_mode = JMODE_W'(JM_JUMP);
          end
          default: begin
            cm_rf_write_addr = WA_RD;
            cm_rf_write_data = WD_ALU;
          end
        endcase
      end
      default: halted = 1'b1;
    endcase
  end

`ifdef MC_CONTROL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles  <= 32'd0;
      perf_retired <= 32'd0;
    end else begin
      if (state_q != ST_ERROR) perf_cycles  <= perf_cycles + 32'd1;
      if (cw_pc_enable)        perf_retired <= perf_retired + 32'd1;
    end
  end
`endif

endmodule
